// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one SRAM-like memory port between the instruction-fetch
//            requester (inst_*) and the data requester (data_*). Address
//            phases are arbitrated with data having priority. A grant that the
//            memory has not yet accepted is locked until it is accepted. Up to
//            DEPTH accepted transactions are tracked in issue order, so each
//            mem_data_ok/mem_rdata is routed back to the requester that issued
//            it.
// Ports    : clk_i, resetn_i                 clock, async active-low reset
//            inst_req_i .. inst_wdata_i      IF request (held until addr_ok)
//            inst_addr_ok_o, inst_data_ok_o  IF handshakes
//            inst_rdata_o                    IF read data
//            data_*                          same set for the data requester
//            mem_req_o .. mem_wdata_o        merged memory request
//            mem_addr_ok_i, mem_data_ok_i    memory handshakes (in order)
//            mem_rdata_i                     memory read data
//            busy_o                          transactions outstanding or lock held
//            proto_err_o                     sticky: response with nothing pending
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  // instruction-fetch requester
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic [3:0]  inst_wstrb_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  // data requester
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  // memory port
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i,
  // status
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wptr_q,  wptr_d;
  logic [AW-1:0]    rptr_q,  rptr_d;
  logic [DEPTH-1:0] ids_q,   ids_d;     // source ID per slot: 0=inst, 1=data
  logic             perr_q,  perr_d;

  logic full;
  logic sel_valid;
  logic sel_data;
  logic push;
  logic pop;
  logic head_id;

  assign full = (count_q == CW'(DEPTH));

  // Grant selection. A locked grant is forwarded regardless of the other
  // requester (and even if the locked requester drops its request), so the
  // memory sees a stable address phase until it accepts it.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!full) begin
          if (data_req_i) begin
            sel_valid = 1'b1;
            sel_data  = 1'b1;
          end else if (inst_req_i) begin
            sel_valid = 1'b1;
            sel_data  = 1'b0;
          end
        end
      end
      ST_LOCK_I: begin
        sel_valid = 1'b1;
        sel_data  = 1'b0;
      end
      ST_LOCK_D: begin
        sel_valid = 1'b1;
        sel_data  = 1'b1;
      end
      default: begin
        sel_valid = 1'b0;
        sel_data  = 1'b0;
      end
    endcase
  end

  // Merged request; payload forced to zero when no grant is active.
  always_comb begin
    mem_req_o   = sel_valid;
    mem_wr_o    = 1'b0;
    mem_size_o  = 2'd0;
    mem_addr_o  = 32'd0;
    mem_wstrb_o = 4'd0;
    mem_wdata_o = 32'd0;
    if (sel_valid) begin
      if (sel_data) begin
        mem_wr_o    = data_wr_i;
        mem_size_o  = data_size_i;
        mem_addr_o  = data_addr_i;
        mem_wstrb_o = data_wstrb_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_wr_o    = inst_wr_i;
        mem_size_o  = inst_size_i;
        mem_addr_o  = inst_addr_i;
        mem_wstrb_o = inst_wstrb_i;
        mem_wdata_o = inst_wdata_i;
      end
    end
  end

  assign push    = sel_valid & mem_addr_ok_i;
  assign pop     = mem_data_ok_i & (count_q != '0);
  assign head_id = ids_q[rptr_q];

  assign inst_addr_ok_o = push & ~sel_data;
  assign data_addr_ok_o = push &  sel_data;
  assign inst_data_ok_o = pop  & ~head_id;
  assign data_data_ok_o = pop  &  head_id;
  assign inst_rdata_o   = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign busy_o      = (count_q != '0) || (state_q != ST_IDLE);
  assign proto_err_o = perr_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    ids_d   = ids_q;
    perr_d  = perr_q | (mem_data_ok_i & (count_q == '0));

    if (push) begin
      ids_d[wptr_q] = sel_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Only reachable with a grant when not full, so a lock is never
        // taken while the FIFO is full.
        if (sel_valid && !mem_addr_ok_i) begin
          state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
        end
      end
      ST_LOCK_I, ST_LOCK_D: begin
        if (mem_addr_ok_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ids_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ids_q   <= ids_d;
      perr_q  <= perr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_arbiter
// Purpose  : Self-checking bench for sram_bus_arbiter. A vector table covers
//            single reads, simultaneous requests, and both lock states;
//            hand-written sequences cover the full FIFO, push+pop, the
//            protocol-error flag and asynchronous reset mid-traffic. Expected
//            response routing comes from a source-ID queue that is pushed when
//            an accept is expected and popped on every memory response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

  localparam logic [31:0] IADDR = 32'h1C00_0000;
  localparam logic [31:0] DADDR = 32'h0000_8000;
  localparam logic [31:0] DWDAT = 32'hDEAD_BEEF;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy, proto_err;

  int checks = 0;
  int errors = 0;
  logic sb[$];   // expected source IDs in issue order: 0=inst, 1=data

  sram_bus_arbiter #(.DEPTH(4)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .inst_req_i(inst_req), .inst_wr_i(inst_wr), .inst_size_i(inst_size),
    .inst_addr_i(inst_addr), .inst_wstrb_i(inst_wstrb), .inst_wdata_i(inst_wdata),
    .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_wr_i(data_wr), .data_size_i(data_size),
    .data_addr_i(data_addr), .data_wstrb_i(data_wstrb), .data_wdata_i(data_wdata),
    .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
    .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
    .mem_addr_ok_i(mem_addr_ok), .mem_data_ok_i(mem_data_ok), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rd;
    logic        emreq, esrc, eiaok, edaok, ebusy, eperr;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, check on the falling edge.
  task automatic cyc(input logic ir, input logic dr, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic emreq, input logic esrc,
                     input logic eiaok, input logic edaok, input logic ebusy,
                     input logic eperr);
    logic have;
    logic exp_id;
    @(posedge clk);
    #1;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    have   = 1'b0;
    exp_id = 1'b0;
    if (dok && sb.size() > 0) begin
      exp_id = sb.pop_front();
      have   = 1'b1;
    end
    if (eiaok) sb.push_back(1'b0);
    if (edaok) sb.push_back(1'b1);
    @(negedge clk);
    chk("mem_req",      {31'd0, mem_req},      {31'd0, emreq});
    chk("mem_addr",     mem_addr,              emreq ? (esrc ? DADDR : IADDR) : 32'd0);
    chk("mem_wr",       {31'd0, mem_wr},       {31'd0, emreq & esrc});
    chk("mem_wstrb",    {28'd0, mem_wstrb},    (emreq & esrc) ? 32'hF : 32'h0);
    chk("mem_wdata",    mem_wdata,             (emreq & esrc) ? DWDAT : 32'd0);
    chk("mem_size",     {30'd0, mem_size},     emreq ? 32'd2 : 32'd0);
    chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, eiaok});
    chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, edaok});
    chk("busy",         {31'd0, busy},         {31'd0, ebusy});
    chk("proto_err",    {31'd0, proto_err},    {31'd0, eperr});
    chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, have & ~exp_id});
    chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, have & exp_id});
    if (have) chk("rdata", exp_id ? data_rdata : inst_rdata, rd);
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  initial begin
    //          ir dr aok dok rd            mreq src iaok daok busy perr
    // single inst read, response two cycles later
    vecs[0]  = '{1, 0, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 1, 32'h02800C0C, 0, 0, 0, 0, 1, 0};
    // simultaneous requests: data first, inst next, responses D then I
    vecs[3]  = '{1, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0};
    vecs[4]  = '{1, 0, 1, 0, 32'h0,        1, 0, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 32'h11111111, 0, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 1, 32'h22222222, 0, 0, 0, 0, 1, 0};
    // inst locked for three cycles while data competes
    vecs[7]  = '{1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 32'h0,        1, 0, 0, 0, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 32'h0,        1, 0, 0, 0, 1, 0};
    vecs[10] = '{1, 1, 1, 0, 32'h0,        1, 0, 1, 0, 1, 0};
    vecs[11] = '{0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 1, 0};
    vecs[12] = '{0, 0, 0, 1, 32'h33333333, 0, 0, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 0, 1, 32'h44444444, 0, 0, 0, 0, 1, 0};
    vecs[14] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0};
    // data locked; inst ignored when it arrives
    vecs[15] = '{0, 1, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 1, 0, 32'h0,        1, 1, 0, 1, 1, 0};
    vecs[17] = '{0, 0, 0, 1, 32'h55555555, 0, 0, 0, 0, 1, 0};
    vecs[18] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0};

    inst_wr = 0; inst_size = 2'd2; inst_addr = IADDR; inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_wr = 1; data_size = 2'd2; data_addr = DADDR; data_wstrb = 4'hF; data_wdata = DWDAT;
    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, checked before release
    chk("rst mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst busy",      {31'd0, busy},      32'd0);
    chk("rst proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst mem_addr",  mem_addr,           32'd0);
    resetn = 1;

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok, vecs[i].rd, vecs[i].emreq,
          vecs[i].esrc, vecs[i].eiaok, vecs[i].edaok, vecs[i].ebusy, vecs[i].eperr);
    end

    // fill to DEPTH, then full blocks requests (no bypass with data_ok)
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 32'h66666666, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 32'h77777777, 0, 0, 0, 0, 1, 0);
    // push+pop at count 3 keeps count 3: one more accept fills, next blocked
    cyc(1, 0, 1, 1, 32'h88888888, 1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'hA0 + i, 0, 0, 0, 0, 1, 0);

    // response with nothing outstanding: ignored, proto_err sticky
    cyc(0, 0, 0, 1, 32'h99999999, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 32'h0, 1, 1, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1, 1);

    // asynchronous reset with two transactions outstanding
    resetn = 0;
    #1;
    chk("async busy",      {31'd0, busy},      32'd0);
    chk("async proto_err", {31'd0, proto_err}, 32'd0);
    chk("async mem_req",   {31'd0, mem_req},   32'd0);
    sb.delete();
    #2;
    resetn = 1;
    // stale response after release must not be routed
    cyc(0, 0, 0, 1, 32'hBBBBBBBB, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
